// File: rtl/branch_tracker_if.sv
// branch_tracker_if: groups the fetch-side prediction, resolution and
// table-update signals of branch_tracker.
//   master : fetch/resolve side (drives pred_*, res_*, flush)
//   slave  : branch_tracker (drives lookup_idx, upd_*, mispredict,
//            full, empty, spec_ghr)
interface branch_tracker_if #(
   parameter int IDXW = 10
);
   logic            pred_valid;
   logic [IDXW-1:0] pred_pc;
   logic            pred_taken;
   logic [IDXW-1:0] lookup_idx;
   logic            res_valid;
   logic            res_taken;
   logic            flush;
   logic            upd_valid;
   logic [IDXW-1:0] upd_idx;
   logic            upd_hit;
   logic            mispredict;
   logic            full;
   logic            empty;
   logic [IDXW-1:0] spec_ghr;

   modport master (
      output pred_valid, pred_pc, pred_taken, res_valid, res_taken, flush,
      input  lookup_idx, upd_valid, upd_idx, upd_hit, mispredict,
             full, empty, spec_ghr
   );

   modport slave (
      input  pred_valid, pred_pc, pred_taken, res_valid, res_taken, flush,
      output lookup_idx, upd_valid, upd_idx, upd_hit, mispredict,
             full, empty, spec_ghr
   );
endinterface

// File: rtl/branch_tracker.sv
// branch_tracker: gshare index generation plus in-order tracking of
// in-flight conditional branch predictions. Each accepted prediction is
// queued with the table index it used; on resolution the head entry is
// popped and returned one cycle later as a counter-table update. Keeps
// speculative and committed global history and repairs the speculative
// history on mispredict or flush.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : branch_tracker_if.slave
//          pred_valid/pred_pc/pred_taken -> lookup_idx (combinational)
//          res_valid/res_taken           -> upd_valid/upd_idx/upd_hit/
//                                           mispredict (registered)
//          flush, full, empty, spec_ghr
module branch_tracker #(
   parameter int IDXW  = 10,
   parameter int DEPTH = 4
) (
   input logic            clk,
   input logic            rst,
   branch_tracker_if.slave bus
);
   localparam int PW = $clog2(DEPTH);

   logic [IDXW-1:0] spec_ghr;
   logic [IDXW-1:0] cmt_ghr;
   logic [IDXW-1:0] fifo_idx  [DEPTH];
   logic            fifo_pred [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [PW:0]     count;

   logic            full;
   logic            empty;
   logic            do_res;
   logic            do_mis;
   logic            do_pred;
   logic            hit;
   logic [IDXW-1:0] lookup_idx;

   assign full       = (count == (PW+1)'(DEPTH));
   assign empty      = (count == '0);
   assign lookup_idx = bus.pred_pc ^ spec_ghr;

   always_comb begin
      do_res  = bus.res_valid & ~empty & ~bus.flush;
      hit     = (fifo_pred[rd_ptr] == bus.res_taken);
      do_mis  = do_res & ~hit;
      // A correct same-cycle pop frees a slot, so a push is allowed even when full.
      do_pred = bus.pred_valid & ~bus.flush & ~do_mis & (~full | do_res);
   end

   // Storage needs no reset: entries are only read while count covers them.
   always_ff @(posedge clk) begin
      if (do_pred) begin
         fifo_idx[wr_ptr]  <= lookup_idx;
         fifo_pred[wr_ptr] <= bus.pred_taken;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spec_ghr <= '0;
         cmt_ghr  <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else if (bus.flush) begin
         spec_ghr <= cmt_ghr;
         wr_ptr   <= rd_ptr;
         count    <= '0;
      end else if (do_mis) begin
         // Repair from committed history, then discard everything younger.
         spec_ghr <= {cmt_ghr[IDXW-2:0], bus.res_taken};
         cmt_ghr  <= {cmt_ghr[IDXW-2:0], bus.res_taken};
         rd_ptr   <= rd_ptr + PW'(1);
         wr_ptr   <= rd_ptr + PW'(1);
         count    <= '0;
      end else begin
         if (do_pred) begin
            spec_ghr <= {spec_ghr[IDXW-2:0], bus.pred_taken};
            wr_ptr   <= wr_ptr + PW'(1);
         end
         if (do_res) begin
            cmt_ghr <= {cmt_ghr[IDXW-2:0], bus.res_taken};
            rd_ptr  <= rd_ptr + PW'(1);
         end
         case ({do_pred, do_res})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   logic            upd_valid_q;
   logic [IDXW-1:0] upd_idx_q;
   logic            upd_hit_q;
   logic            mispredict_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         upd_valid_q  <= 1'b0;
         upd_idx_q    <= '0;
         upd_hit_q    <= 1'b0;
         mispredict_q <= 1'b0;
      end else begin
         upd_valid_q  <= do_res;
         mispredict_q <= do_mis;
         if (do_res) begin
            upd_idx_q <= fifo_idx[rd_ptr];
            upd_hit_q <= hit;
         end
      end
   end

   assign bus.lookup_idx = lookup_idx;
   assign bus.upd_valid  = upd_valid_q;
   assign bus.upd_idx    = upd_idx_q;
   assign bus.upd_hit    = upd_hit_q;
   assign bus.mispredict = mispredict_q;
   assign bus.full       = full;
   assign bus.empty      = empty;
   assign bus.spec_ghr   = spec_ghr;
endmodule

// File: doc/branch_tracker.md
# branch_tracker

Speculative-history and resolution tracker feeding the 1024-entry pattern counter table. It forms the gshare table index for each fetched conditional branch, records in-flight predictions in program order, and on branch resolution returns the update for that table: the index used at prediction time and whether the prediction was correct. It also maintains speculative and committed global history and repairs the speculative history on a mispredict or flush.

## Interface
- IDXW, 10: table index and history width. Must match the 1024-entry counter table.
- DEPTH, 4: maximum in-flight predicted branches. Must be a power of two, at least 2.

- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high. This is the only reset.
- pred_valid  in  1  conditional branch fetched this cycle, with its prediction taken from the table.
- pred_pc  in  IDXW  branch PC word-index bits.
- pred_taken  in  1  prediction value read from the table.
- lookup_idx  out  IDXW  combinational: pred_pc XOR spec_ghr. Drives the table read address.
- res_valid  in  1  oldest in-flight branch resolved this cycle.
- res_taken  in  1  actual outcome of that branch.
- flush  in  1  pipeline flush. Discards all in-flight branches.
- upd_valid  out  1  registered one-cycle pulse: table update.
- upd_idx  out  IDXW  registered table index to update.
- upd_hit  out  1  registered: 1 = prediction was correct (counter strengthens), 0 = wrong (counter weakens).
- mispredict  out  1  registered one-cycle pulse, asserted alongside upd_valid when upd_hit = 0.
- full  out  1  combinational: count == DEPTH. Fetch must stall.
- empty  out  1  combinational: count == 0.
- spec_ghr  out  IDXW  speculative global history.

## Operation
- State:
  - spec_ghr and cmt_ghr, both IDXW wide.
  - Circular FIFO of DEPTH entries, each {idx[IDXW-1:0], pred}.
  - Read and write pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - count, log2(DEPTH)+1 bits.
- Accept pred: pred_valid & !full & !flush & !(resolve with mispredict this cycle).
  - Push {lookup_idx, pred_taken}.
  - spec_ghr <= {spec_ghr[IDXW-2:0], pred_taken}.
- Accept res: res_valid & !empty & !flush.
  - Pop the head entry.
  - hit = (head.pred == res_taken).
  - cmt_ghr <= {cmt_ghr[IDXW-2:0], res_taken}.
  - Next cycle: upd_valid = 1, upd_idx = head.idx, upd_hit = hit, mispredict = !hit.
- Mispredict on an accepted res:
  - All younger entries are discarded; count <= 0 and pointers are equalized.
  - spec_ghr <= {cmt_ghr[IDXW-2:0], res_taken}.
  - A same-cycle pred is dropped.
- Simultaneous accepted pred and correct res: push and pop together, count unchanged. This is legal when full, because the pop frees a slot in the same cycle.
- flush has priority over everything:
  - FIFO emptied, spec_ghr <= cmt_ghr.
  - A same-cycle res is ignored: no update, no cmt_ghr change.
  - A same-cycle pred is dropped.
- res_valid while empty: ignored, no upd_valid.
- pred_valid while full (and no same-cycle pop): dropped, no state change. This is a protocol violation for the fetch stage; the bench flags it.
- Non-branch cycles: hold all state. upd_valid and mispredict return to 0.

## Timing
- On rst assertion, immediately:
  - spec_ghr = 0, cmt_ghr = 0, FIFO empty, pointers 0, count 0.
  - upd_valid = 0, upd_idx = 0, upd_hit = 0, mispredict = 0.
  - Therefore full = 0, empty = 1, lookup_idx = pred_pc.
- Reset mid-operation discards all in-flight entries. No update pulse is emitted for them.
- lookup_idx has zero latency and always uses spec_ghr as registered before the current edge.
- Update latency: exactly 1 cycle from the accepted res edge to the upd_* outputs.
- Update throughput: 1 per cycle, back-to-back.
- full and empty reflect count after the previous edge.
- With DEPTH = 4, the 5th outstanding pred without an intervening res is dropped.

## Test plan
- Reset, then pred_valid with pred_pc=0x155, pred_taken=1:
  - lookup_idx = 0x155.
  - Next cycle spec_ghr = 0x001, count = 1.
- Three preds, then three correct res (res_taken = pred), all after reset:
  - Three upd_valid pulses on consecutive cycles, upd_hit = 1 each.
  - upd_idx values equal the pushed lookup_idx values in order.
  - Final cmt_ghr = spec_ghr.
- Two preds (pred_taken = 1, 1), then res_taken = 0 on the first:
  - upd_hit = 0, mispredict = 1.
  - count = 0, spec_ghr = 0x000 (cmt_ghr = 0x000).
  - A second res is then ignored.
- Fill to DEPTH=4, then one more pred alone:
  - The extra pred is dropped and full stays 1.
  - Then pred together with a correct res: count stays 4, pointers wrap, and the new entry pops last with correct idx.
- Flush with 3 in flight, cmt_ghr = 0x2AA, plus a same-cycle res_valid:
  - No upd_valid.
  - empty = 1, spec_ghr = 0x2AA.
- Assert rst asynchronously mid-clock with 2 entries in flight and upd_valid high:
  - All outputs reach reset values before the next edge.
  - No later update pulse appears.
